pipe_scheduler: RTL and testbench

Sequences the pipe-height ROM (2-bit index in, 10-bit top-edge Y out, combinational) and owns the horizontal state of the three on-screen pipe obstacles. On each frame tick it scrolls all pipes left. It retires any pipe that has left the screen and respawns it at the right with a fresh ROM height chosen by an LFSR. It pulses score when a pipe passes the bird. It sits between the VGA timing / game FSM and the obstacle draw and collision logic.

---
 rtl/pipe_pkg.sv | 28 ++
 rtl/pipe_lfsr8.sv | 18 +
 rtl/pipe_scheduler.sv | 175 +++++++++++++++++
 tb/tb_pipe_scheduler.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants for the pipe obstacle scheduler: state codes,
// coordinate widths, default geometry and the LFSR polynomial.
package pipe_pkg;

  localparam int XW = 11;
  localparam int YW = 10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_FETCH = 3'd3;
  localparam logic [2:0] ST_PAUSE = 3'd4;

  localparam int DEF_SPAWN_X = 640;
  localparam int DEF_SPACING = 220;
  localparam int DEF_PIPE_W  = 60;
  localparam int DEF_BIRD_X  = 200;

  // x^8+x^6+x^5+x^4+1 as bit taps 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(
    input logic [7:0] q
  );
    return {q[6:0], ^(q & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pipe_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR, reusable by any game element
// that needs a cheap pseudo-random source.
module pipe_lfsr8
  import pipe_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  always_ff @(posedge clk) begin
    if (rst) q <= SEED;
    else     q <= lfsr_next(q);
  end

endmodule

// File: rtl/pipe_scheduler.sv
// Scrolls, retires and respawns three pipes; sequences the height ROM.
// Define SPEED_RAMP_EN to raise the scroll speed every 8 pipes passed.
module pipe_scheduler
  import pipe_pkg::*;
#(
  parameter int         SPAWN_X   = DEF_SPAWN_X,
  parameter int         SPACING   = DEF_SPACING,
  parameter int         PIPE_W    = DEF_PIPE_W,
  parameter int         SPEED     = 2,
  parameter int         BIRD_X    = DEF_BIRD_X,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 frame_tick,
  output logic [1:0]           rom_index,
  input  logic [YW-1:0]        rom_y,
  output logic signed [XW-1:0] pipe_x0,
  output logic signed [XW-1:0] pipe_x1,
  output logic signed [XW-1:0] pipe_x2,
  output logic [YW-1:0]        pipe_y0,
  output logic [YW-1:0]        pipe_y1,
  output logic [YW-1:0]        pipe_y2,
  output logic [2:0]           pipe_valid,
  output logic                 score_pulse,
  output logic                 busy
);

  localparam logic signed [XW-1:0] NEG_W =
    XW'(-PIPE_W);
  localparam logic signed [XW-1:0] WRAP =
    XW'(3 * SPACING);
  // crossing tested on the left edge so x+W never overflows
  localparam logic signed [XW-1:0] EDGE =
    XW'(BIRD_X - PIPE_W);

  logic [2:0]           state;
  logic [1:0]           slot;
  logic                 phase;
  logic                 pending;
  logic [7:0]           lfsr;
  logic                 unused_lfsr;
  logic signed [XW-1:0] px [3];
  logic [YW-1:0]        py [3];
  logic signed [XW-1:0] nx [3];
  logic signed [XW-1:0] step;
  logic                 ret_any;
  logic [1:0]           ret_slot;
  logic                 any_cross;
  logic                 tick_due;

  pipe_lfsr8 #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr)
  );

  assign unused_lfsr = ^lfsr[7:2];

  assign tick_due = (state == ST_RUN) && run
                 && (frame_tick || pending);

`ifdef SPEED_RAMP_EN
  logic [2:0] passed;
  logic [3:0] speed;

  always_ff @(posedge clk) begin
    if (rst) begin
      passed <= '0;
      speed  <= 4'(SPEED);
    end else if (tick_due && any_cross) begin
      passed <= passed + 3'd1;
      if (passed == 3'd7 && speed < 4'd7)
        speed <= speed + 4'd1;
    end
  end

  assign step = {{(XW-4){1'b0}}, speed};
`else
  assign step = XW'(SPEED);
`endif

  always_comb begin
    ret_any   = 1'b0;
    ret_slot  = 2'd0;
    any_cross = 1'b0;
    for (int i = 0; i < 3; i++) begin
      nx[i] = px[i] - step;
      if (nx[i] <= NEG_W && !ret_any) begin
        ret_any  = 1'b1;
        ret_slot = 2'(i);
      end
      if (px[i] > EDGE && nx[i] <= EDGE)
        any_cross = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      slot        <= 2'd0;
      phase       <= 1'b0;
      pending     <= 1'b0;
      rom_index   <= 2'd0;
      score_pulse <= 1'b0;
      pipe_valid  <= 3'b000;
      px[0]       <= XW'(SPAWN_X);
      px[1]       <= XW'(SPAWN_X + SPACING);
      px[2]       <= XW'(SPAWN_X + 2 * SPACING);
      for (int i = 0; i < 3; i++)
        py[i] <= '0;
    end else begin
      score_pulse <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (run) begin
            state <= ST_LOAD;
            slot  <= 2'd0;
            phase <= 1'b0;
          end
        end
        ST_LOAD, ST_FETCH: begin
          if (frame_tick) pending <= 1'b1;
          if (!phase) begin
            rom_index <= lfsr[1:0];
            phase     <= 1'b1;
          end else begin
            py[slot]         <= rom_y;
            pipe_valid[slot] <= 1'b1;
            phase            <= 1'b0;
            if (state == ST_LOAD && slot != 2'd2)
              slot <= slot + 2'd1;
            else
              state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!run) begin
            state <= ST_PAUSE;
            if (frame_tick) pending <= 1'b1;
          end else if (tick_due) begin
            pending     <= 1'b0;
            score_pulse <= any_cross;
            for (int i = 0; i < 3; i++)
              px[i] <= (ret_any && ret_slot == 2'(i))
                     ? nx[i] + WRAP : nx[i];
            if (ret_any) begin
              state <= ST_FETCH;
              slot  <= ret_slot;
              phase <= 1'b0;
            end
          end
        end
        ST_PAUSE: begin
          if (frame_tick) pending <= 1'b1;
          if (run) state <= ST_RUN;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign pipe_x0 = px[0];
  assign pipe_x1 = px[1];
  assign pipe_x2 = px[2];
  assign pipe_y0 = py[0];
  assign pipe_y1 = py[1];
  assign pipe_y2 = py[2];
  assign busy    = (state == ST_LOAD)
                || (state == ST_FETCH);

endmodule

// File: tb/tb_pipe_scheduler.sv
// Bench for pipe_scheduler: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, random phase.
module tb_pipe_scheduler;

  localparam int SPAWN = 640;
  localparam int SPC   = 180;
  localparam int W     = 60;
  localparam int BX    = 200;
  localparam int SPD   = 2;
  localparam logic [7:0] SEED = 8'hA5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0;
  logic frame_tick = 1'b0;
  logic [1:0] rom_index;
  logic [9:0] rom_y;
  logic signed [10:0] pipe_x0, pipe_x1, pipe_x2;
  logic [9:0] pipe_y0, pipe_y1, pipe_y2;
  logic [2:0] pipe_valid;
  logic score_pulse, busy;

  int rom_tab [4] = '{100, 150, 200, 250};
  assign rom_y = 10'(rom_tab[rom_index]);

  pipe_scheduler #(
    .SPAWN_X(SPAWN), .SPACING(SPC), .PIPE_W(W),
    .SPEED(SPD), .BIRD_X(BX), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .run(run),
    .frame_tick(frame_tick),
    .rom_index(rom_index), .rom_y(rom_y),
    .pipe_x0(pipe_x0), .pipe_x1(pipe_x1),
    .pipe_x2(pipe_x2),
    .pipe_y0(pipe_y0), .pipe_y1(pipe_y1),
    .pipe_y2(pipe_y2),
    .pipe_valid(pipe_valid),
    .score_pulse(score_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name,
                     input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, exp);
    end
  endtask

  // reference model: game progress as a queue of pending ROM jobs
  bit [7:0] m_lfsr;
  int       m_idx;
  int       m_x [3];
  int       m_y [3];
  bit [2:0] m_valid;
  bit       m_score, m_pend, m_started, m_paused;
  int       job_q [$];
  bit       job_half;
  int       m_spd, m_passed;

  task automatic m_reset();
    m_lfsr = SEED;
    m_idx = 0;
    for (int i = 0; i < 3; i++) begin
      m_x[i] = SPAWN + i * SPC;
      m_y[i] = 0;
    end
    m_valid = 3'b000;
    m_score = 1'b0;
    m_pend = 1'b0;
    m_started = 1'b0;
    m_paused = 1'b0;
    job_q.delete();
    job_half = 1'b0;
    m_spd = SPD;
    m_passed = 0;
  endtask

  always @(posedge clk) begin : model
    bit [7:0] lf;
    bit hit;
    int nx, s;
    lf = m_lfsr;
    if (rst) begin
      m_reset();
    end else begin
      m_lfsr = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
      m_score = 1'b0;
      if (!m_started) begin
        if (run) begin
          m_started = 1'b1;
          job_q = '{0, 1, 2};
          job_half = 1'b0;
        end
      end else if (job_q.size() != 0) begin
        if (frame_tick) m_pend = 1'b1;
        if (!job_half) begin
          m_idx = int'(lf[1:0]);
          job_half = 1'b1;
        end else begin
          s = job_q.pop_front();
          m_y[s] = rom_tab[m_idx];
          m_valid[s] = 1'b1;
          job_half = 1'b0;
        end
      end else if (m_paused) begin
        if (frame_tick) m_pend = 1'b1;
        if (run) m_paused = 1'b0;
      end else if (!run) begin
        m_paused = 1'b1;
        if (frame_tick) m_pend = 1'b1;
      end else if (frame_tick || m_pend) begin
        m_pend = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 3; i++) begin
          nx = m_x[i] - m_spd;
          if (m_x[i] + W > BX && nx + W <= BX) hit = 1'b1;
          if (nx <= -W && job_q.size() == 0) begin
            nx += 3 * SPC;
            job_q.push_back(i);
            job_half = 1'b0;
          end
          m_x[i] = nx;
        end
        m_score = hit;
`ifdef SPEED_RAMP_EN
        if (hit) begin
          m_passed = (m_passed + 1) % 8;
          if (m_passed == 0 && m_spd < 7) m_spd++;
        end
`endif
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("x0", int'(pipe_x0), m_x[0]);
      chk("x1", int'(pipe_x1), m_x[1]);
      chk("x2", int'(pipe_x2), m_x[2]);
      chk("y0", int'(pipe_y0), m_y[0]);
      chk("y1", int'(pipe_y1), m_y[1]);
      chk("y2", int'(pipe_y2), m_y[2]);
      chk("valid", int'(pipe_valid), int'(m_valid));
      chk("rom_index", int'(rom_index), m_idx);
      chk("score", int'(score_pulse), int'(m_score));
      chk("busy", int'(busy), int'(job_q.size() != 0));
    end
  end

  task automatic cyc(input bit r, input bit t);
    run = r;
    frame_tick = t;
    @(negedge clk);
  endtask

  function automatic bit in_rom(input int y);
    return y == 100 || y == 150 || y == 200 || y == 250;
  endfunction

  int busy_cnt, sc_cnt;

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_x0", int'(pipe_x0), 640);
    chk("rst_x1", int'(pipe_x1), 820);
    chk("rst_x2", int'(pipe_x2), 1000);
    chk("rst_valid", int'(pipe_valid), 0);
    chk("rst_busy", int'(busy), 0);
    rst = 1'b0;

    cyc(1, 0);
    busy_cnt = 0;
    repeat (10) begin
      if (busy) busy_cnt++;
      cyc(1, 0);
    end
    chk("load_busy_cycles", busy_cnt, 6);
    chk("load_valid", int'(pipe_valid), 7);
    chk("load_x2", int'(pipe_x2), 1000);
    chk("load_y0_rom", int'(in_rom(int'(pipe_y0))), 1);

    sc_cnt = 0;
    repeat (200) begin
      cyc(1, 1);
      if (score_pulse) sc_cnt++;
    end
    chk("scroll200_x0", int'(pipe_x0), 240);
    chk("scroll200_x2", int'(pipe_x2), 600);
    chk("scroll200_score", sc_cnt, 0);

    repeat (49) cyc(1, 1);
    chk("pre_cross_x0", int'(pipe_x0), 142);
    cyc(1, 1);
    chk("cross_score", int'(score_pulse), 1);
    cyc(1, 1);
    chk("after_cross_score", int'(score_pulse), 0);

    repeat (98) cyc(1, 1);
    chk("pre_retire_x0", int'(pipe_x0), -58);
    cyc(1, 1);
    chk("retire_x0", int'(pipe_x0), 480);
    chk("retire_busy", int'(busy), 1);
    cyc(1, 1);
    cyc(1, 0);
    chk("fetch_done_busy", int'(busy), 0);
    chk("fetch_y0_rom", int'(in_rom(int'(pipe_y0))), 1);
    chk("fetch_x1_held", int'(pipe_x1), 120);
    cyc(1, 0);
    chk("pending_x1", int'(pipe_x1), 118);
    cyc(1, 0);
    chk("pending_once_x1", int'(pipe_x1), 118);

    cyc(0, 0);
    cyc(0, 1);
    cyc(0, 1);
    cyc(1, 0);
    chk("pause_x1_held", int'(pipe_x1), 118);
    cyc(1, 0);
    cyc(1, 0);
    chk("pause_one_tick_x1", int'(pipe_x1), 116);

    for (int k = 0; k < 2000 && !busy; k++) cyc(1, 1);
    chk("fetch_reached", int'(busy), 1);
    cyc(1, 0);
    chk("fetch_b_busy", int'(busy), 1);
    rst = 1'b1;
    cyc(1, 0);
    rst = 1'b0;
    chk("mid_rst_x0", int'(pipe_x0), 640);
    chk("mid_rst_valid", int'(pipe_valid), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_y0", int'(pipe_y0), 0);

    for (int k = 0; k < 4000; k++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 19) == 0) run = ~run;
      cyc(run, $urandom_range(0, 2) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
